// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller driving external single-port tag and data SRAMs.
// Misses refill a whole line in word order and forward the requested word as it arrives.
module icache_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_SETS   = 256,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned OFF_W      = $clog2(DATA_W / 8),
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS),
  localparam int unsigned IDX_W      = $clog2(NUM_SETS),
  localparam int unsigned LINE_OFF_W = OFF_W + WORD_W,
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - LINE_OFF_W,
  localparam int unsigned DADDR_W    = IDX_W + WORD_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fetch_req_i,
  input  logic [ADDR_W-1:0]  fetch_addr_i,
  output logic               fetch_gnt_o,
  output logic               fetch_rvalid_o,
  output logic [DATA_W-1:0]  fetch_rdata_o,
  input  logic               flush_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic               tag_req_o,
  output logic               tag_we_o,
  output logic [IDX_W-1:0]   tag_addr_o,
  output logic [TAG_W:0]     tag_wdata_o,
  input  logic [TAG_W:0]     tag_rdata_i,
  output logic               data_req_o,
  output logic               data_we_o,
  output logic [DADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0]  data_wdata_o,
  input  logic [DATA_W-1:0]  data_rdata_i
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic                   flush_pending_q, flush_pending_d;
  logic [ADDR_W-1:OFF_W]  addr_q, addr_d;
  logic [WORD_W-1:0]      beat_q, beat_d;
  logic [IDX_W-1:0]       flush_idx_q, flush_idx_d;

  logic [IDX_W-1:0]  idx_q, f_idx;
  logic [WORD_W-1:0] word_q, f_word;
  logic [TAG_W-1:0]  tag_q;
  logic              hit, last_beat, unused_addr_bits;

  assign idx_q            = addr_q[LINE_OFF_W +: IDX_W];
  assign word_q           = addr_q[OFF_W +: WORD_W];
  assign tag_q            = addr_q[ADDR_W-1 -: TAG_W];
  assign f_idx            = fetch_addr_i[LINE_OFF_W +: IDX_W];
  assign f_word           = fetch_addr_i[OFF_W +: WORD_W];
  assign unused_addr_bits = ^fetch_addr_i[OFF_W-1:0];

  assign hit       = tag_rdata_i[TAG_W] && (tag_rdata_i[TAG_W-1:0] == tag_q);
  assign last_beat = (beat_q == WORD_W'(LINE_WORDS - 1));
  // A pending flush blocks new fetches so it is serviced before the next lookup.
  assign fetch_gnt_o = (state_q == IDLE) && fetch_req_i && !flush_pending_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      flush_pending_q <= 1'b0;
      addr_q          <= '0;
      beat_q          <= '0;
      flush_idx_q     <= '0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      addr_q          <= addr_d;
      beat_q          <= beat_d;
      flush_idx_q     <= flush_idx_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q | flush_i;
    addr_d          = addr_q;
    beat_d          = beat_q;
    flush_idx_d     = flush_idx_q;
    case (state_q)
      IDLE: begin
        flush_idx_d = '0;
        if (flush_pending_q) begin
          state_d = FLUSH;
        end else if (fetch_req_i) begin
          state_d = LOOKUP;
          addr_d  = fetch_addr_i[ADDR_W-1:OFF_W];
        end
      end
      LOOKUP:   state_d = hit ? IDLE : MISS_REQ;
      MISS_REQ: begin
        if (mem_gnt_i) begin
          state_d = REFILL;
          beat_d  = '0;
        end
      end
      REFILL: begin
        if (mem_rvalid_i) begin
          beat_d = beat_q + WORD_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      FLUSH: begin
        flush_idx_d = flush_idx_q + IDX_W'(1);
        if (flush_idx_q == IDX_W'(NUM_SETS - 1)) begin
          state_d         = IDLE;
          // a pulse landing on the final flush cycle still needs its own pass
          flush_pending_d = flush_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_rvalid_o = 1'b0;
    fetch_rdata_o  = '0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    tag_req_o      = 1'b0;
    tag_we_o       = 1'b0;
    tag_addr_o     = '0;
    tag_wdata_o    = '0;
    data_req_o     = 1'b0;
    data_we_o      = 1'b0;
    data_addr_o    = '0;
    data_wdata_o   = '0;
    case (state_q)
      IDLE: begin
        if (fetch_gnt_o) begin
          tag_req_o   = 1'b1;
          tag_addr_o  = f_idx;
          data_req_o  = 1'b1;
          data_addr_o = {f_idx, f_word};
        end
      end
      LOOKUP: begin
        if (hit) begin
          fetch_rvalid_o = 1'b1;
          fetch_rdata_o  = data_rdata_i;
        end
      end
      MISS_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
      end
      REFILL: begin
        if (mem_rvalid_i) begin
          data_req_o   = 1'b1;
          data_we_o    = 1'b1;
          data_addr_o  = {idx_q, beat_q};
          data_wdata_o = mem_rdata_i;
          if (beat_q == word_q) begin
            fetch_rvalid_o = 1'b1;
            fetch_rdata_o  = mem_rdata_i;
          end
          // the tag goes valid only once the whole line is in the data SRAM
          if (last_beat) begin
            tag_req_o   = 1'b1;
            tag_we_o    = 1'b1;
            tag_addr_o  = idx_q;
            tag_wdata_o = {1'b1, tag_q};
          end
        end
      end
      FLUSH: begin
        tag_req_o  = 1'b1;
        tag_we_o   = 1'b1;
        tag_addr_o = flush_idx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural SRAMs and backing memory, a valid/tag array reference
// model, directed scenarios followed by randomized fetches with occasional flushes.
module tb_icache_ctrl;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int NUM_SETS   = 256;
  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 19;
  localparam int IDX_W      = 8;
  localparam int DADDR_W    = 10;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               fetch_req_i, fetch_gnt_o, fetch_rvalid_o;
  logic [ADDR_W-1:0]  fetch_addr_i;
  logic [DATA_W-1:0]  fetch_rdata_o;
  logic               flush_i;
  logic               mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [DATA_W-1:0]  mem_rdata_i;
  logic               tag_req_o, tag_we_o;
  logic [IDX_W-1:0]   tag_addr_o;
  logic [TAG_W:0]     tag_wdata_o, tag_rdata_i;
  logic               data_req_o, data_we_o;
  logic [DADDR_W-1:0] data_addr_o;
  logic [DATA_W-1:0]  data_wdata_o, data_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  icache_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_addr_o(tag_addr_o),
    .tag_wdata_o(tag_wdata_o), .tag_rdata_i(tag_rdata_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  // Single-port SRAMs; the tag array comes out of reset all-invalid.
  logic [TAG_W:0]    tag_mem  [NUM_SETS];
  logic [DATA_W-1:0] data_mem [NUM_SETS*LINE_WORDS];
  int tag_zero_wr = 0;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SETS; i++) tag_mem[i] <= '0;
    end else if (tag_req_o) begin
      if (tag_we_o) begin
        tag_mem[tag_addr_o] <= tag_wdata_o;
        if (tag_wdata_o == '0) tag_zero_wr <= tag_zero_wr + 1;
      end else begin
        tag_rdata_i <= tag_mem[tag_addr_o];
      end
    end
  end

  always @(posedge clk_i) begin
    if (data_req_o) begin
      if (data_we_o) data_mem[data_addr_o] <= data_wdata_o;
      else           data_rdata_i <= data_mem[data_addr_o];
    end
  end

  // Reference model: which line each set holds.
  bit          ref_valid [NUM_SETS];
  int unsigned ref_tag   [NUM_SETS];

  function automatic logic [DATA_W-1:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:3], 3'b000};
    return {w ^ 32'hDEAD_BEEF, ~w};
  endfunction

  function automatic logic any_output();
    return |{fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, mem_req_o, mem_addr_o,
             tag_req_o, tag_we_o, tag_addr_o, tag_wdata_o,
             data_req_o, data_we_o, data_addr_o, data_wdata_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic clear_ref();
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
  endtask

  // One fetch transaction, optionally preceded by a flush pulse, with a flush pulse
  // during the refill, or with reset asserted after beat rst_beat of the refill.
  task automatic do_fetch(input logic [31:0] addr, input bit pre_flush, input bit mid_flush,
                          input int rst_beat);
    logic [31:0] line;
    int unsigned idx, word, tg;
    bit          exp_hit, dut_hit;
    int          cyc, zero0, delay, gap;
    line = {addr[31:5], 5'b0};
    idx  = addr[12:5];
    word = addr[4:3];
    tg   = addr[31:13];
    @(negedge clk_i);
    if (pre_flush) begin
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      zero0   = tag_zero_wr;
      clear_ref();
    end
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    fetch_req_i  = 1'b1;
    fetch_addr_i = addr;
    #1;
    cyc = 0;
    while (!fetch_gnt_o && cyc < NUM_SETS + 20) begin
      @(negedge clk_i); #1; cyc++;
    end
    chk("fetch_gnt", fetch_gnt_o, 1'b1);
    if (!fetch_gnt_o) begin
      fetch_req_i = 1'b0;
      return;
    end
    if (pre_flush) begin
      chk("flush_tag_writes", tag_zero_wr - zero0, NUM_SETS);
      chk("flush_gnt_delay", cyc, NUM_SETS + 1);
    end
    chk("lookup_reads", {tag_req_o, tag_we_o, tag_addr_o, data_req_o, data_we_o, data_addr_o},
        {1'b1, 1'b0, addr[12:5], 1'b1, 1'b0, addr[12:3]});

    @(negedge clk_i);
    mem_rvalid_i = ($urandom_range(0, 3) == 0);
    mem_rdata_i  = {$urandom, $urandom};
    #1;
    chk("lookup_no_gnt", fetch_gnt_o, 1'b0);
    chk("lookup_hit", fetch_rvalid_o, exp_hit);
    dut_hit = fetch_rvalid_o;
    if (dut_hit) chk("hit_rdata", fetch_rdata_o, mem_word(addr));
    @(negedge clk_i);
    fetch_req_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    if (dut_hit) begin
      #1;
      chk("hit_no_mem_req", mem_req_o, 1'b0);
      return;
    end

    delay = $urandom_range(0, 2);
    for (int d = 0; d <= delay; d++) begin
      if (d > 0) @(negedge clk_i);
      mem_gnt_i = (d == delay);
      #1;
      chk("mem_req", mem_req_o, 1'b1);
      chk("mem_addr", mem_addr_o, line);
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    for (int b = 0; b < LINE_WORDS; b++) begin
      gap = $urandom_range(0, 1);
      repeat (gap) begin
        #1;
        chk("gap_rvalid", fetch_rvalid_o, 1'b0);
        @(negedge clk_i);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(line + 32'(b * 8));
      flush_i      = mid_flush && (b == 1);
      #1;
      chk("fwd_rvalid", fetch_rvalid_o, b == int'(word));
      if (b == int'(word)) chk("fwd_rdata", fetch_rdata_o, mem_word(addr));
      chk("refill_data_wr", {data_req_o, data_we_o, data_addr_o}, {2'b11, addr[12:5], 2'(b)});
      chk("refill_tag_wr", tag_req_o && tag_we_o, b == LINE_WORDS - 1);
      if (b == LINE_WORDS - 1)
        chk("refill_tag_val", {tag_addr_o, tag_wdata_o}, {addr[12:5], 1'b1, addr[31:13]});
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      flush_i      = 1'b0;
      if (b + 1 == rst_beat) begin
        rst_ni = 1'b0;
        #1;
        chk("rst_outputs_zero", any_output(), 1'b0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        clear_ref();
        return;
      end
    end
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tg;
    if (mid_flush) begin
      #1;
      chk("post_refill_idle", tag_req_o, 1'b0);
      @(negedge clk_i);
      #1;
      chk("flush_starts", {tag_req_o, tag_we_o, tag_addr_o, tag_wdata_o}, {2'b11, 8'd0, 20'd0});
      clear_ref();
    end
  endtask

  initial begin
    logic [31:0] a;
    int          sel, r;
    bit          last_mid;
    fetch_req_i  = 1'b0;
    fetch_addr_i = '0;
    flush_i      = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    clear_ref();
    repeat (4) @(negedge clk_i);
    #1;
    chk("reset_outputs", any_output(), 1'b0);
    rst_ni = 1'b1;

    do_fetch(32'h0000_0018, 1'b0, 1'b0, 0);
    chk("tag0_after_cold", tag_mem[0], {1'b1, 19'd0});
    do_fetch(32'h0000_0008, 1'b0, 1'b0, 0);
    do_fetch(32'h0000_2000, 1'b0, 1'b0, 0);
    chk("tag0_after_tag1", tag_mem[0], {1'b1, 19'd1});
    do_fetch(32'h0000_0000, 1'b0, 1'b0, 0);
    do_fetch(32'h0000_2000, 1'b1, 1'b0, 0);
    do_fetch(32'h0000_0040, 1'b0, 1'b1, 0);
    do_fetch(32'h0000_2000, 1'b0, 1'b0, 0);
    do_fetch(32'h0000_0018, 1'b0, 1'b0, 2);
    do_fetch(32'h0000_0018, 1'b0, 1'b0, 0);

    last_mid = 1'b1;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 3);
      r   = $urandom_range(0, 19);
      a   = {19'($urandom_range(0, 2)), 8'((sel == 3) ? 255 : sel),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      do_fetch(a, (r == 0) && !last_mid, r == 1, 0);
      last_mid = (r == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
